// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the request-unit state encoding.
// Imported by the request unit and the testbench.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } ru_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Cleared asynchronously by nRST.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // count enabled cycles, holding once the maximum is reached
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer: issues fetch/load/store requests,
// strobes the PC once per instruction and latches halt.
module request_unit
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        cuIRE,
    input  logic        cuDRE,
    input  logic        cuDWE,
    input  logic        cuHALT,
    input  logic        ihit,
    input  logic        dhit,
    input  word_t       aluaddr,
    input  word_t       rdat2,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output word_t       dmemaddr,
    output word_t       dmemstore,
    output logic        pcEN,
    output logic        halt,
    output logic [31:0] stall_cnt
);

    ru_state_t state;
    ru_state_t next_state;

    logic in_idle;
    logic in_dwait;
    logic go_halt;
    logic go_mem;
    logic mem_done;
    logic stall;

    assign in_idle  = (state == IDLE);
    assign in_dwait = (state == DWAIT);
    assign go_halt  = in_idle & ihit & cuHALT;
    assign go_mem   = in_idle & ihit & ~cuHALT & (cuDRE | cuDWE);
    assign mem_done = in_dwait & dhit;

    // state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (go_halt) begin
                    next_state = HALTED;
                end else if (go_mem) begin
                    next_state = DWAIT;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    next_state = IDLE;
                end
            end
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    // combinational outputs: fetch request, PC strobe, stall qualifier
    always_comb begin
        iREN  = cuIRE & in_idle;
        pcEN  = 1'b0;
        stall = 1'b0;
        unique case (state)
            IDLE: begin
                pcEN  = ihit & ~cuHALT & ~cuDRE & ~cuDWE;
                stall = ~ihit;
            end
            DWAIT: begin
                pcEN  = dhit;
                stall = ~dhit;
            end
            default: begin
                pcEN  = 1'b0;
                stall = 1'b0;
            end
        endcase
        pcEN = pcEN & nRST;
    end

    // registered data request, latched address/data and sticky halt
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dREN      <= 1'b0;
            dWEN      <= 1'b0;
            dmemaddr  <= '0;
            dmemstore <= '0;
            halt      <= 1'b0;
        end else begin
            if (go_mem) begin
                dREN      <= cuDRE;
                dWEN      <= cuDWE & ~cuDRE;
                dmemaddr  <= aluaddr;
                dmemstore <= rdat2;
            end else if (mem_done) begin
                dREN <= 1'b0;
                dWEN <= 1'b0;
            end
            if (go_halt) begin
                halt <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH(32)
    ) u_stall (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (stall),
        .count(stall_cnt)
    );

endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 nRST  input  1  asynchronous active-low reset.
REQ-004 cuIRE  input  1  instruction read enable from the control unit.
REQ-005 cuDRE  input  1  load request from the control unit.
REQ-006 cuDWE  input  1  store request from the control unit.
REQ-007 cuHALT  input  1  halt opcode decoded.
REQ-008 ihit  input  1  instruction memory returned a valid word this cycle.
REQ-009 dhit  input  1  data memory completed the outstanding access this cycle.
REQ-010 aluaddr  input  32 (word_t)  effective address from the ALU.
REQ-011 rdat2  input  32 (word_t)  store data from the register file.
REQ-012 iREN  output  1  instruction fetch request to memory.
REQ-013 dREN  output  1  data read request, registered.
REQ-014 dWEN  output  1  data write request, registered.
REQ-015 dmemaddr  output  32 (word_t)  latched data address, stable while a request is pending.
REQ-016 dmemstore  output  32 (word_t)  latched store data, stable while a request is pending.
REQ-017 pcEN  output  1  one-cycle PC advance strobe.
REQ-018 halt  output  1  sticky halt indication.
REQ-019 stall_cnt  output  32  saturating count of stalled cycles.

Function
REQ-020 States SHALL be IDLE, DWAIT and HALTED; the reset state SHALL be IDLE.
REQ-021 IDLE with ihit=0: stay in IDLE; pcEN=0; stall_cnt increments.
REQ-022 IDLE with ihit=1, cuHALT=1: go to HALTED, set halt=1, pcEN=0; cuHALT takes priority over cuDRE/cuDWE.
REQ-023 IDLE with ihit=1, cuDRE=1 or cuDWE=1: go to DWAIT, register dREN=cuDRE, dWEN=cuDWE & ~cuDRE, capture aluaddr->dmemaddr and rdat2->dmemstore, pcEN=0.
REQ-024 Simultaneous cuDRE and cuDWE SHALL be treated as a load: the read wins and dWEN stays 0.
REQ-025 IDLE with ihit=1 and no memory op or halt: pcEN=1 for that cycle; stay in IDLE.
REQ-026 DWAIT with dhit=0: hold dREN/dWEN/dmemaddr/dmemstore unchanged; iREN=0; pcEN=0; stall_cnt increments.
REQ-027 DWAIT with dhit=1: pcEN=1 that cycle; dREN and dWEN clear on the next edge; return to IDLE.
REQ-028 Minimum memory-instruction latency: 1 cycle ihit in IDLE + 1 or more cycles in DWAIT; pcEN pulses exactly once per instruction.
REQ-029 dhit in IDLE or HALTED SHALL be ignored; ihit in DWAIT or HALTED SHALL be ignored.
REQ-030 iREN SHALL be combinational: cuIRE & (state==IDLE).
REQ-031 HALTED SHALL be terminal until reset: iREN=dREN=dWEN=pcEN=0, halt=1, stall_cnt frozen.
REQ-032 stall_cnt SHALL saturate at 32'hFFFFFFFF, with no wrap.
REQ-033 dmemaddr and dmemstore SHALL change only on the IDLE->DWAIT transition.

Reset
REQ-034 On nRST low, regardless of state, the block SHALL enter IDLE asynchronously and clear all registered outputs: dREN=dWEN=0, dmemaddr=dmemstore=0, halt=0, stall_cnt=0.
REQ-035 A reset asserted in DWAIT SHALL abandon the pending access, with no pcEN pulse.
REQ-036 pcEN SHALL be 0 while nRST is low.

Structure
REQ-037 The ru_state_t enum (IDLE, DWAIT, HALTED) SHALL be added to cpu_types_pkg; ports use the existing word_t.
REQ-038 The saturating counter SHALL be a sub-module, sat_counter, parameterised on width, with inputs CLK, nRST, en and output count.
REQ-039 The register stage and next-state logic SHALL be separate always_ff / always_comb blocks.

Verification
REQ-040 Plain ALU op: ihit=1, cuDRE=cuDWE=0 for 3 cycles -> pcEN=1 on each cycle, state stays IDLE, stall_cnt=0.
REQ-041 Load with wait: ihit=1, cuDRE=1, aluaddr=32'h0000_0040, then dhit=0 for 2 cycles then dhit=1 -> dREN=1 for 3 cycles, dmemaddr=32'h40 throughout, a single pcEN pulse on the dhit cycle, stall_cnt=2.
REQ-042 Store with input churn: cuDWE=1, rdat2=32'hDEAD_BEEF, then rdat2 and aluaddr change during DWAIT -> dmemstore holds 32'hDEADBEEF, dWEN=1 until dhit.
REQ-043 Conflict and halt: cuDRE=cuDWE=1 -> dREN=1, dWEN=0; later ihit=1, cuHALT=1 -> halt=1 sticky, iREN=0, later ihit/dhit have no effect.
REQ-044 Reset mid-access: nRST low 1 cycle while in DWAIT -> immediate IDLE, dREN=0, stall_cnt=0, no pcEN.
REQ-045 Saturation: force the counter to 32'hFFFFFFFE, then stall 3 cycles -> stall_cnt=32'hFFFFFFFF and holds.
